// File: rtl/uart_tx_ctrl_if.sv
// UART transmit controller bundle.
// Groups the byte-source request, the serializer handshake and the line/status outputs.
//   p_data     : byte to transmit, sampled on accept
//   data_valid : request to send p_data
//   par_en     : insert parity bit, sampled on accept
//   par_typ    : 0 = even, 1 = odd, sampled on accept
//   ser_data   : serial bit presented by the serializer
//   ser_done   : serializer is presenting its last data bit
//   ser_en     : serializer shift enable
//   tx_out     : registered UART line
//   busy       : frame in progress
// master: byte source plus serializer side; slave: the frame sequencer.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  ser_data;
  logic                  ser_done;
  logic                  ser_en;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, ser_data, ser_done,
    input  ser_en, tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, ser_data, ser_done,
    output ser_en, tx_out, busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer.
// Accepts a parallel byte, drives the serializer shift enable, computes parity and muxes
// start/data/parity/stop bits onto a registered line. Frame on the line:
//   start(0), DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits(1).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_ctrl_if slave modport (request, serializer handshake, tx_out, busy)
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_ctrl_if.slave bus
);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_stop_bits_check
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  localparam logic [1:0] StopLast = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  parity_q;
  logic                  par_en_q;
  logic [1:0]            stop_cnt_q;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  sel_bit;
  logic                  ser_en;

  assign p_data = bus.p_data;

  // Bit the line will carry one cycle from now.
  always_comb begin
    sel_bit = 1'b1;
    case (state_q)
      StStart:  sel_bit = 1'b0;
      StData:   sel_bit = bus.ser_data;
      StParity: sel_bit = parity_q;
      default:  sel_bit = 1'b1;
    endcase
  end

  // Shift stops on the last data bit so the serializer holds its final position.
  assign ser_en = (state_q == StStart) || ((state_q == StData) && !bus.ser_done);

  // busy_q is updated alongside every transition into/out of StIdle, so it always
  // equals (state_q != StIdle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      parity_q   <= 1'b0;
      par_en_q   <= 1'b0;
      stop_cnt_q <= 2'd0;
    end else begin
      tx_q <= sel_bit;
      case (state_q)
        StIdle: begin
          if (bus.data_valid && !busy_q) begin
            parity_q <= (^p_data) ^ bus.par_typ;
            par_en_q <= bus.par_en;
            state_q  <= StStart;
            busy_q   <= 1'b1;
          end
        end
        StStart: state_q <= StData;
        StData: begin
          if (bus.ser_done) state_q <= par_en_q ? StParity : StStop;
        end
        StParity: state_q <= StStop;
        StStop: begin
          if (stop_cnt_q == StopLast) begin
            stop_cnt_q <= 2'd0;
            state_q    <= StIdle;
            busy_q     <= 1'b0;
          end else begin
            stop_cnt_q <= stop_cnt_q + 2'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ser_en = ser_en;
  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (one and two stop bits) share stimulus, each with
// its own serializer model. Expected frames come from a bit-list model of the UART frame.
module tb_uart_tx_ctrl;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  int            checks = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus0 ();
  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus1 ();

  assign bus0.p_data = p_data;
  assign bus0.data_valid = data_valid;
  assign bus0.par_en = par_en;
  assign bus0.par_typ = par_typ;
  assign bus1.p_data = p_data;
  assign bus1.data_valid = data_valid;
  assign bus1.par_en = par_en;
  assign bus1.par_typ = par_typ;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Serializer models: load the next queued byte on the first enabled shift of a frame,
  // then advance one bit per enabled cycle.
  logic [DW-1:0] sq0[$];
  logic [DW-1:0] sq1[$];
  logic [DW-1:0] by0, by1;
  logic [3:0]    idx0, idx1;
  logic          ld0, ld1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld0 <= 1'b0; idx0 <= 4'd0; by0 <= '0;
    end else if (!bus0.busy) begin
      ld0 <= 1'b0;
    end else if (bus0.ser_en) begin
      if (!ld0) begin
        ld0 <= 1'b1; idx0 <= 4'd0;
        if (sq0.size() > 0) by0 <= sq0.pop_front();
        else by0 <= '0;
      end else idx0 <= idx0 + 4'd1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld1 <= 1'b0; idx1 <= 4'd0; by1 <= '0;
    end else if (!bus1.busy) begin
      ld1 <= 1'b0;
    end else if (bus1.ser_en) begin
      if (!ld1) begin
        ld1 <= 1'b1; idx1 <= 4'd0;
        if (sq1.size() > 0) by1 <= sq1.pop_front();
        else by1 <= '0;
      end else idx1 <= idx1 + 4'd1;
    end
  end

  assign bus0.ser_data = ld0 ? by0[idx0[2:0]] : 1'b0;
  assign bus0.ser_done = ld0 && (idx0 == 4'(DW - 1));
  assign bus1.ser_data = ld1 ? by1[idx1[2:0]] : 1'b0;
  assign bus1.ser_done = ld1 && (idx1 == 4'(DW - 1));

  // A frame that never leaves DATA keeps busy high forever; flag it once.
  int stuck0 = 0;
  int stuck1 = 0;
  always @(negedge clk) begin
    if (bus0.busy === 1'b1) stuck0++; else stuck0 = 0;
    if (bus1.busy === 1'b1) stuck1++; else stuck1 = 0;
    if (stuck0 == 64 || stuck1 == 64) begin
      checks++; fails++;
      $display("FAIL watchdog busy stuck high: got %0d/%0d cycles, required < 64", stuck0, stuck1);
    end
  end

  function automatic logic tx_of(input int i);
    return (i == 0) ? bus0.tx_out : bus1.tx_out;
  endfunction
  function automatic logic busy_of(input int i);
    return (i == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic sen_of(input int i);
    return (i == 0) ? bus0.ser_en : bus1.ser_en;
  endfunction
  function automatic int stops_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  // Reference frame as a list of line bits: bit n is the line value n cycles after START.
  function automatic void model_frame(input logic [DW-1:0] b, input logic pe, input logic pt,
                                      input int stops, output logic [31:0] bits,
                                      output int len);
    int ones;
    bits = '1;
    ones = 0;
    bits[0] = 1'b0;
    len = 1;
    for (int k = 0; k < DW; k++) begin
      bits[len] = b[k];
      if (b[k]) ones++;
      len++;
    end
    if (pe) begin
      bits[len] = ((ones % 2) == 1) ^ pt;
      len++;
    end
    len += stops;
  endfunction

  // Called on the negedge where the DUT sits in START; samples len further negedges.
  task automatic collect(input int i, input int len, output logic [31:0] bits,
                         output int nbusy, output int nsen);
    bits = '1;
    nbusy = busy_of(i) ? 1 : 0;
    nsen = sen_of(i) ? 1 : 0;
    for (int n = 0; n < len; n++) begin
      @(negedge clk);
      bits[n] = tx_of(i);
      if (busy_of(i)) nbusy++;
      if (sen_of(i)) nsen++;
    end
  endtask

  task automatic test_reset();
    data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({tx_of(i), busy_of(i), sen_of(i)} !== 3'b100) begin
        fails++;
        $display("FAIL reset_values inst%0d tx/busy/ser_en got %b%b%b expected 100",
                 i, tx_of(i), busy_of(i), sen_of(i));
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({tx_of(i), busy_of(i), sen_of(i)} !== 3'b100) begin
          fails++;
          $display("FAIL idle cycle %0d inst%0d tx/busy/ser_en got %b%b%b expected 100",
                   c, i, tx_of(i), busy_of(i), sen_of(i));
        end
      end
    end
  endtask

  task automatic test_single_frame(input string name, input logic [DW-1:0] b, input logic pe,
                                   input logic pt);
    logic [31:0] eb0, eb1, ob0, ob1;
    int el0, el1, nb0, nb1, ns0, ns1;
    model_frame(b, pe, pt, stops_of(0), eb0, el0);
    model_frame(b, pe, pt, stops_of(1), eb1, el1);
    @(negedge clk);
    p_data = b; par_en = pe; par_typ = pt; data_valid = 1'b1;
    sq0.push_back(b); sq1.push_back(b);
    @(negedge clk);
    // Inputs wander mid-frame; the latched frame must not change.
    data_valid = 1'b0; p_data = DW'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
    fork
      collect(0, el0, ob0, nb0, ns0);
      collect(1, el1, ob1, nb1, ns1);
    join
    checks++;
    if (ob0 !== eb0) begin
      fails++; $display("FAIL %s inst0 frame got %h expected %h", name, ob0, eb0);
    end
    checks++;
    if (ob1 !== eb1) begin
      fails++; $display("FAIL %s inst1 frame got %h expected %h", name, ob1, eb1);
    end
    checks++;
    if (nb0 !== el0 || nb1 !== el1) begin
      fails++;
      $display("FAIL %s busy cycles got %0d/%0d expected %0d/%0d", name, nb0, nb1, el0, el1);
    end
    checks++;
    if (ns0 !== DW || ns1 !== DW) begin
      fails++;
      $display("FAIL %s ser_en cycles got %0d/%0d expected %0d", name, ns0, ns1, DW);
    end
    @(negedge clk);
    checks++;
    if ({tx_of(0), busy_of(0), tx_of(1), busy_of(1)} !== 4'b1010) begin
      fails++;
      $display("FAIL %s post_idle tx/busy got %b%b %b%b expected 10 10", name,
               tx_of(0), busy_of(0), tx_of(1), busy_of(1));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea0, ea1, eb0, eb1, oa0, oa1, ob0, ob1;
    int la0, la1, lb0, lb1, d0, d1, d2, d3, d4, d5, d6, d7;
    logic g0, g1;
    model_frame(8'h3C, 1'b1, 1'b1, stops_of(0), ea0, la0);
    model_frame(8'h3C, 1'b1, 1'b1, stops_of(1), ea1, la1);
    model_frame(8'hC3, 1'b1, 1'b1, stops_of(0), eb0, lb0);
    model_frame(8'hC3, 1'b1, 1'b1, stops_of(1), eb1, lb1);
    @(negedge clk);
    p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
    sq0.push_back(8'h3C); sq0.push_back(8'hC3);
    sq1.push_back(8'h3C); sq1.push_back(8'hC3);
    @(negedge clk);
    p_data = 8'hC3;
    fork
      begin
        collect(0, la0, oa0, d0, d1);
        @(negedge clk);
        g0 = tx_of(0);
        collect(0, lb0, ob0, d2, d3);
      end
      begin
        collect(1, la1, oa1, d4, d5);
        @(negedge clk);
        g1 = tx_of(1);
        collect(1, lb1, ob1, d6, d7);
      end
      begin
        // Held until the slower instance has accepted its second byte.
        repeat (la1 + 1) @(negedge clk);
        data_valid = 1'b0;
      end
    join
    checks++;
    if (oa0 !== ea0 || oa1 !== ea1) begin
      fails++;
      $display("FAIL b2b first frame got %h/%h expected %h/%h", oa0, oa1, ea0, ea1);
    end
    checks++;
    if (ob0 !== eb0 || ob1 !== eb1) begin
      fails++;
      $display("FAIL b2b second frame got %h/%h expected %h/%h", ob0, ob1, eb0, eb1);
    end
    checks++;
    if ({g0, g1} !== 2'b11) begin
      fails++; $display("FAIL b2b gap bit got %b%b expected 11", g0, g1);
    end
    checks++;
    if (d0 !== la0 || d2 !== lb0 || d4 !== la1 || d6 !== lb1) begin
      fails++;
      $display("FAIL b2b busy cycles got %0d %0d %0d %0d expected %0d %0d %0d %0d",
               d0, d2, d4, d6, la0, lb0, la1, lb1);
    end
    @(negedge clk);
    checks++;
    if ({busy_of(0), busy_of(1), tx_of(0), tx_of(1)} !== 4'b0011) begin
      fails++;
      $display("FAIL b2b no_third_frame busy/tx got %b%b %b%b expected 00 11",
               busy_of(0), busy_of(1), tx_of(0), tx_of(1));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] b;
    b = DW'($urandom);
    @(negedge clk);
    p_data = b; par_en = 1'b1; par_typ = 1'($urandom); data_valid = 1'b1;
    sq0.push_back(b); sq1.push_back(b);
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({tx_of(i), busy_of(i), sen_of(i)} !== 3'b100) begin
        fails++;
        $display("FAIL reset_mid_frame inst%0d tx/busy/ser_en got %b%b%b expected 100",
                 i, tx_of(i), busy_of(i), sen_of(i));
      end
    end
    sq0.delete(); sq1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    test_single_frame("after_reset", ~b, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++)
      test_single_frame("random", DW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_single_frame("a5_even", 8'hA5, 1'b1, 1'b0);
    test_single_frame("07_odd", 8'h07, 1'b1, 1'b1);
    test_single_frame("07_even", 8'h07, 1'b1, 1'b0);
    test_single_frame("ff_nopar", 8'hFF, 1'b0, 1'b0);
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmit path.
- Accepts a parallel byte, drives the serializer's shift enable, and computes parity.
- Muxes start, data, parity and stop bits onto a registered serial line, and reports BUSY upstream.
- Sits between the byte source and the TX pin, wrapping the existing serializer.

Parameters:
DATA_WIDTH, 8, payload bits per frame; parity and SER_DONE contract are sized to it.
STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  byte to transmit, sampled on accept
DATA_VALID  input  1  request to send P_DATA
PAR_EN  input  1  1 = insert parity bit, sampled on accept
PAR_TYP  input  1  0 = even, 1 = odd, sampled on accept
SER_DATA  input  1  serial bit from serializer
SER_DONE  input  1  serializer reports last data bit present
SER_EN  output  1  serializer shift enable
TX_OUT  output  1  UART line, registered
BUSY  output  1  frame in progress; upstream must not present new data

Behaviour:
- One clock; reset is asynchronous and active-low (CLK, RST). Polarity and synchronicity are fixed.
- Reset values: state=IDLE, TX_OUT=1, BUSY=0, SER_EN=0, parity_bit=0, stop counter=0, latched PAR_EN/PAR_TYP=0.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: in IDLE with DATA_VALID=1 and BUSY=0 at a rising edge, the block:
  - latches parity_bit = (^P_DATA) XOR PAR_TYP;
  - latches PAR_EN;
  - moves to START.
- DATA_VALID in any other state is ignored. Nothing is queued.
- BUSY is registered and equals (state != IDLE). It rises the cycle after accept and falls the cycle after leaving STOP.
- START lasts 1 cycle, selected bit = 0, then the FSM goes to DATA.
- SER_EN is combinational: 1 in START, and 1 in DATA while SER_DONE=0. It is 0 everywhere else.
- Serializer contract:
  - bit0 appears on SER_DATA in the first DATA cycle;
  - bit k appears in DATA cycle k+1;
  - SER_DONE=1 during the cycle presenting bit DATA_WIDTH-1.
- DATA: selected bit = SER_DATA. On SER_DONE=1 the FSM goes to PARITY if latched PAR_EN=1, else to STOP. DATA therefore lasts exactly DATA_WIDTH cycles.
- PARITY lasts 1 cycle, selected bit = parity_bit, then STOP.
- STOP: selected bit = 1. It holds STOP_BITS cycles using the stop counter, then goes to IDLE.
- IDLE: selected bit = 1.
- TX_OUT <= selected bit every cycle. The line therefore lags the state by exactly one cycle.
- Frame length on TX_OUT: 1 + DATA_WIDTH + PAR_EN + STOP_BITS cycles.
- Minimum gap between frames: one IDLE cycle. The next accept is possible the first cycle BUSY=0.
- Config changes mid-frame: P_DATA, PAR_EN and PAR_TYP changing mid-frame have no effect on the current frame.
- SER_DONE outside DATA is ignored.
- SER_DONE never asserted in DATA: the FSM stays in DATA. This is a system error, not recovered here; the bench must flag it.
- Reset mid-frame: the block returns immediately (asynchronously) to reset values, and TX_OUT goes to 1 without completing the frame.
- DATA_VALID held high continuously: one frame is sent, then the next byte is accepted in the first IDLE cycle. Back-to-back frames are separated by exactly one idle-high cycle.

Test Plan:
- Reset then idle 5 cycles with DATA_VALID=0 -> TX_OUT=1, BUSY=0, SER_EN=0 throughout.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle DATA_VALID -> TX_OUT from the cycle after START entry is 0,1,0,1,0,0,1,0,1,0,1 (11 bits; parity 0). BUSY is high 11 cycles. SER_EN is high 8 cycles (START plus the first 7 DATA cycles).
- P_DATA=0x07, PAR_EN=1, PAR_TYP=1 -> parity bit 0. The same byte with PAR_TYP=0 -> parity bit 1.
- P_DATA=0xFF, PAR_EN=0, STOP_BITS=2 -> TX_OUT is 0, eight 1s, then 1,1. The frame is 11 cycles with no parity slot.
- DATA_VALID held high with P_DATA=0x3C, then 0xC3 -> two complete frames with exactly one idle-high cycle between them. The second frame carries 0xC3, and DATA_VALID pulses during the frame are ignored.
- Assert RST low in the 4th DATA cycle -> TX_OUT=1, BUSY=0, SER_EN=0 immediately. After RST release with DATA_VALID=1, a fresh full frame is sent.
